// File: rtl/count_pkg.sv
// Shared constants and state encoding for the count game sequencer and display side.
package count_pkg;

  localparam int unsigned NUM_W              = 3;
  localparam int unsigned DEF_TICKS_PER_STEP = 1000;
  localparam int unsigned DEF_START_NUM      = 7;
  localparam int unsigned DEF_BLINK_TICKS    = 250;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/count_seq_ctrl_key_sync_edge.sv
// Two-flop synchronizer for a raw key followed by a one-cycle rising-edge pulse.
module key_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Countdown sequencer driving the dot-matrix digit and enable.
// Optional done-state blink is built when COUNT_SEQ_CTRL_BLINK_EN is defined.
module count_seq_ctrl
  import count_pkg::*;
#(
  parameter int unsigned TICKS_PER_STEP = DEF_TICKS_PER_STEP,
  parameter int unsigned START_NUM      = DEF_START_NUM,
  parameter int unsigned BLINK_TICKS    = DEF_BLINK_TICKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_pause,
  output logic [NUM_W-1:0] num,
  output logic             st,
  output logic             step,
  output logic             done,
  output state_t           dbg_state
);

  localparam int unsigned      TW        = $clog2(TICKS_PER_STEP);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICKS_PER_STEP - 1);
  localparam logic [NUM_W-1:0] START_V   = NUM_W'(START_NUM);

  if (TICKS_PER_STEP < 2) begin : g_bad_ticks
    $error("TICKS_PER_STEP must be at least 2");
  end
  if (START_NUM > 7) begin : g_bad_start
    $error("START_NUM must be 0..7");
  end
  if (BLINK_TICKS < 1) begin : g_bad_blink
    $error("BLINK_TICKS must be at least 1");
  end

  logic start_edge;
  logic pause_edge;

  key_sync_edge u_start_sync (
    .clk    (clk),
    .rst    (rst),
    .key_i  (key_start),
    .edge_o (start_edge)
  );

  key_sync_edge u_pause_sync (
    .clk    (clk),
    .rst    (rst),
    .key_i  (key_pause),
    .edge_o (pause_edge)
  );

  state_t           state_q;
  logic [TW-1:0]    tick_q;
  logic [NUM_W-1:0] num_q;
  logic             st_q;
  logic             step_q;
  logic             done_q;

`ifdef COUNT_SEQ_CTRL_BLINK_EN
  localparam int unsigned   BW         = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  logic [BW-1:0] blink_q;
`endif

  // Start has top priority in every state; terminal tick beats pause in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      num_q   <= START_V;
      st_q    <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef COUNT_SEQ_CTRL_BLINK_EN
      blink_q <= '0;
`endif
    end else begin
      step_q <= 1'b0;
      if (start_edge) begin
        state_q <= RUN;
        tick_q  <= '0;
        num_q   <= START_V;
        st_q    <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            st_q  <= 1'b0;
            num_q <= START_V;
          end
          RUN: begin
            st_q <= 1'b1;
            if (tick_q == TICK_LAST) begin
              tick_q <= '0;
              if (num_q != '0) begin
                num_q  <= num_q - 1'b1;
                step_q <= 1'b1;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
`ifdef COUNT_SEQ_CTRL_BLINK_EN
                blink_q <= '0;
`endif
              end
            end else if (pause_edge) begin
              state_q <= PAUSE;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
          end
          PAUSE: begin
            st_q <= 1'b1;
            if (pause_edge) state_q <= RUN;
          end
          DONE: begin
            num_q  <= '0;
            done_q <= 1'b1;
`ifdef COUNT_SEQ_CTRL_BLINK_EN
            if (blink_q == BLINK_LAST) begin
              blink_q <= '0;
              st_q    <= ~st_q;
            end else begin
              blink_q <= blink_q + 1'b1;
            end
`else
            st_q <= 1'b1;
`endif
          end
          default: begin
            state_q <= IDLE;
            tick_q  <= '0;
            num_q   <= START_V;
            st_q    <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign num       = num_q;
  assign st        = st_q;
  assign step      = step_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
Countdown sequencer for the count game. It owns the digit value and display enable that feed the 8x8 dot-matrix driver: `num` is driven onto the driver's 3-bit digit input and `st` onto its active-high enable. It takes start/pause keys and steps the digit down from START_NUM to 0 at a fixed tick rate, then holds in a done state. It runs on the same 1 kHz scan clock as the display driver.

Parameters:
- TICKS_PER_STEP, 1000: clk cycles each digit is held (1 s at 1 kHz); legal range is 2 or more.
- START_NUM, 7: first digit shown; legal range is 0 to 7.
- BLINK_TICKS, 250: half-period of the done-state blink, in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system/scan clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- key_start  in  1  raw start key, active-high, asynchronous to clk.
- key_pause  in  1  raw pause key, active-high, asynchronous to clk.
- num  out  3  digit to display; goes to the display driver's digit input.
- st  out  1  display enable; 0 blanks the matrix.
- step  out  1  one-cycle pulse in the cycle num decrements.
- done  out  1  level; high while in DONE.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low.
- Reset values: state=IDLE, num=START_NUM, st=0, step=0, done=0, tick=0, all key sync/edge flops=0.
- All outputs are registered; there is no combinational path from input to output.
- Key path: 2-flop synchronizer, then a registered previous-value flop. edge = sync2 & ~prev.
  - A key held high from before clk edge 1 is acted on at rising edge 3.
  - A held key produces exactly one edge. A key must go low for at least 2 cycles before it re-triggers.
- tick counter width is $clog2(TICKS_PER_STEP). It advances only in RUN.
- IDLE: st=0, num=START_NUM.
  - start edge: go to RUN; tick=0, num=START_NUM, st=1.
  - pause edge: ignored.
- RUN: tick increments every cycle.
  - At tick==TICKS_PER_STEP-1: tick wraps to 0.
    - If num>0: num decrements and step=1 for that cycle.
    - If num==0: go to DONE and set done=1.
  - Each digit, including 0, is held exactly TICKS_PER_STEP cycles.
  - A full run from entry to done=1 takes (START_NUM+1)*TICKS_PER_STEP cycles.
  - pause edge: go to PAUSE; tick and num freeze, st stays 1.
  - start edge: restart with tick=0 and num=START_NUM; state stays RUN.
- PAUSE: num and tick held, st=1.
  - pause edge: back to RUN; counting resumes from the frozen tick with no lost cycle.
  - start edge: restart into RUN, same as above.
- DONE: num=0, done=1, st=1.
  - start edge: restart into RUN and clear done in the same cycle.
  - pause edge: ignored.
- Simultaneous start and pause edges: start wins everywhere, including IDLE and DONE.
- Terminal tick coinciding with a pause edge: the decrement (or the DONE transition) happens first, and pause is ignored in that cycle.
  - Exception: if a start edge also arrives in that cycle, start overrides the decrement.
- rst asserted mid-operation: all state returns to reset values immediately; there is no pending edge after release.
- Illegal state encoding: recover to IDLE.

Optional Feature:
- Macro: COUNT_SEQ_CTRL_BLINK_EN.
- When defined:
  - In DONE, st toggles every BLINK_TICKS cycles, so the final 0 flashes.
  - st=1 on the cycle of DONE entry.
  - The blink counter clears on DONE entry.
  - Leaving DONE forces st=1 (RUN) and stops blinking.
- When undefined: st is held at 1 in DONE, and there is no blink counter or BLINK_TICKS logic.

Decomposition:
- Shared package count_pkg:
  - state typedef with states IDLE, RUN, PAUSE, DONE.
  - NUM_W=3.
  - Default TICKS_PER_STEP and START_NUM constants, shared with the display-side code.
- Sub-module key_sync_edge: 2-flop sync plus rising-edge pulse with the same rst. Instantiated twice, once for start and once for pause.

Test Plan (TICKS_PER_STEP=4, START_NUM=7, BLINK_TICKS=2):
- Release rst, start key high 1 cycle before edge 1 -> st=1, num=7 at edge 3. num steps 7,6,...,0, 4 cycles each. step pulses 7 times. done=1 exactly 32 cycles after RUN entry.
- Pause edge while num=5 and tick=2 -> num stays 5 for 10 cycles. A second pause edge resumes, and num becomes 4 after 1 more tick (tick 2 -> 3 -> wrap).
- Start and pause edges in the same cycle during RUN at num=3 -> num=7, state RUN, tick=0, no PAUSE.
- In DONE, pulse pause -> no change. Pulse start -> done=0, num=7, counting restarts.
- Assert rst (0) at num=2 mid-RUN -> num=7, st=0, done=0 immediately. After release, no count until a new start edge.
- With COUNT_SEQ_CTRL_BLINK_EN: in DONE, st reads 1,1,0,0,1,1... and num=0 throughout. Without the macro, st stays 1 steadily.
